reg_mem_arbiter: RTL
====================

Name: reg_mem_arbiter

Overview:
- Two-requester round-robin arbiter and access sequencer for the single-port reg_mem register memory.
- Each requester issues one read or write at a time under a req/ack handshake.
- The block drives reg_mem's addr/data_in/wen and captures data_out for reads.
- It sits between reg_mem and two client blocks, such as a host loader and a datapath engine.

Parameters:
- DATA_WIDTH, 8, width of data words; must match reg_mem.
- ADDR_BITS, 5, address width; must match reg_mem.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req0  input  1  requester 0 access request; held high until ack0.
- we0  input  1  requester 0: 1 = write, 0 = read; stable while req0 is high.
- addr0  input  ADDR_BITS  requester 0 address.
- wdata0  input  DATA_WIDTH  requester 0 write data.
- req1, we1, addr1, wdata1  input  1/1/ADDR_BITS/DATA_WIDTH  same fields for requester 1.
- ack0  output  1  one-cycle completion pulse to requester 0.
- ack1  output  1  one-cycle completion pulse to requester 1.
- rdata  output  DATA_WIDTH  read result; valid in the ack cycle of a read; holds until the next read completes.
- busy  output  1  high whenever the state is not IDLE.
- mem_addr  output  ADDR_BITS  to reg_mem addr.
- mem_data_in  output  DATA_WIDTH  to reg_mem data_in.
- mem_wen  output  1  to reg_mem wen.
- mem_data_out  input  DATA_WIDTH  from reg_mem data_out (combinational read of mem_addr).

Behaviour:
- Clock and reset:
  - One clock, clk.
  - Reset rst_n is asynchronous, active-low.
- Reset values:
  - State = IDLE, last-served pointer = 1, so requester 0 wins the first tie.
  - ack0 = ack1 = 0, rdata = 0, busy = 0.
  - mem_addr = 0, mem_data_in = 0, mem_wen = 0.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - No request: stay in IDLE.
  - Exactly one req high: grant that requester.
  - Both high: grant the requester that was not last served, then update the pointer.
  - On grant, register addrN/wdataN/weN into mem_addr/mem_data_in/an internal we_q, record the grant id, and go to ACCESS.
- ACCESS (exactly one cycle):
  - mem_wen = we_q; mem_wen is combinational from state and we_q, and is 0 in every other state.
  - reg_mem writes at the closing edge when we_q = 1.
  - At the closing edge, a read captures mem_data_out into rdata; a write leaves rdata unchanged.
  - Next state: DONE.
- DONE (exactly one cycle):
  - ack of the granted requester = 1 (registered, set on the ACCESS->DONE edge); the other ack = 0.
  - Next state: IDLE. Requests are not sampled in DONE.
- Handshake rules:
  - Requester holds req/we/addr/wdata until it sees ack.
  - Requester may deassert req in the cycle after ack, or keep it high to request again.
  - A request still high on return to IDLE is a new request.
- Latency: req sampled high at edge E0 in IDLE → mem_wen (write) high during E0–E1 → ack high during E1–E2 → IDLE after E2.
- Throughput: one access every 3 cycles maximum.
- Fairness: with both requesting continuously, grants alternate 0,1,0,1…
- mem_addr and mem_data_in hold their last granted values outside ACCESS; they change only on a grant.
- Width rules: no arithmetic; addresses pass straight through; all 2^ADDR_BITS addresses are legal, including 0 and 2^ADDR_BITS−1.
- Reset mid-operation:
  - rst_n low in ACCESS drops mem_wen immediately; the write does not occur and no ack is issued.
  - rst_n low in DONE clears ack immediately.
  - After rst_n is released, the first rising edge behaves as IDLE.
- A requester changing we/addr/wdata while req is high and before ack is a protocol violation. The captured values at grant are used.

Test Plan:
- Reset then idle: no req for 5 cycles → busy = 0, mem_wen = 0 throughout, ack0 = ack1 = 0, rdata = 0.
- Single write then read, requester 0: write 8'h5A to addr 5'd3 → mem_wen high one cycle with mem_addr = 3, ack0 one cycle later. Then read addr 3 → rdata = 8'h5A in the ack0 cycle.
- Simultaneous requests, first tie after reset: req0 write 8'h11 @ 5'd0, req1 write 8'h22 @ 5'd31, both held → requester 0 served first, requester 1 next. Readback gives addr 0 = 8'h11, addr 31 = 8'h22.
- Continuous contention: both hold req for 12 cycles, reading addrs 10 and 20 → ack sequence 0,1,0,1 spaced 3 cycles apart; rdata in each ack cycle is the matching stored value.
- Fill/readback sweep: requester 1 writes i+10 to addresses 0–31 in order, then reads all 32 → every read returns i+10; 32 acks per phase.
- Reset mid-ACCESS: assert rst_n low during the ACCESS cycle of a write of 8'hFF to addr 7 → mem_wen falls at once and no ack appears. A later read of addr 7 returns the prior value.

Source files
------------

// File: rtl/reg_mem_arbiter.sv
// rtl/reg_mem_arbiter.sv - two-requester round-robin arbiter and access sequencer for reg_mem
// IDLE grants and captures the request, ACCESS drives reg_mem for one cycle, DONE pulses the ack.
module reg_mem_arbiter #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_BITS  = 5
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req0,
   input  logic                  we0,
   input  logic [ADDR_BITS-1:0]  addr0,
   input  logic [DATA_WIDTH-1:0] wdata0,
   input  logic                  req1,
   input  logic                  we1,
   input  logic [ADDR_BITS-1:0]  addr1,
   input  logic [DATA_WIDTH-1:0] wdata1,
   output logic                  ack0,
   output logic                  ack1,
   output logic [DATA_WIDTH-1:0] rdata,
   output logic                  busy,
   output logic [ADDR_BITS-1:0]  mem_addr,
   output logic [DATA_WIDTH-1:0] mem_data_in,
   output logic                  mem_wen,
   input  logic [DATA_WIDTH-1:0] mem_data_out
);

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

   state_t state;
   logic   last;
   logic   gnt;
   logic   we_q;
   logic   grant0;
   logic   grant1;

   // requester 0 wins unless requester 1 also asks and 0 was served last
   assign grant0 = req0 && (!req1 || last);
   assign grant1 = req1 && !grant0;

   assign mem_wen = (state == ACCESS) && we_q;
   assign busy    = (state != IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         last        <= 1'b1;
         gnt         <= 1'b0;
         we_q        <= 1'b0;
         ack0        <= 1'b0;
         ack1        <= 1'b0;
         rdata       <= '0;
         mem_addr    <= '0;
         mem_data_in <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (grant0 || grant1) begin
                  gnt         <= grant1;
                  last        <= grant1;
                  mem_addr    <= grant1 ? addr1 : addr0;
                  mem_data_in <= grant1 ? wdata1 : wdata0;
                  we_q        <= grant1 ? we1 : we0;
                  state       <= ACCESS;
               end
            end
            ACCESS: begin
               if (!we_q) begin
                  rdata <= mem_data_out;
               end
               ack0  <= !gnt;
               ack1  <= gnt;
               state <= DONE;
            end
            DONE: begin
               ack0  <= 1'b0;
               ack1  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
